// File: rtl/riscv_sram_controller.sv
// rtl/riscv_sram_controller.sv - 32-bit bus word to byte-wide async SRAM bridge, four byte beats per access
// Optional one-word read buffer compiled in with SRAM_READ_BUFFER_EN.
module riscv_sram_controller #(
  parameter int ADDRESS_WIDTH = 18,
  parameter int WAIT_CYCLES   = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [31:0]              address,
  input  logic                     read,
  input  logic                     write,
  input  logic [31:0]              write_data,
  output logic [31:0]              read_data,
  output logic                     ready,
  output logic [31:0]              address_requested,
  output logic [ADDRESS_WIDTH-1:0] sram_address,
  output logic [7:0]               sram_data_out,
  input  logic [7:0]               sram_data_in,
  output logic                     sram_data_oe,
  output logic                     sram_we_n,
  output logic                     sram_oe_n
);
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} state_t;
  localparam logic [3:0] LAST_WAIT = 4'(WAIT_CYCLES);

  state_t                   state_q, state_d;
  logic [1:0]               beat_q, beat_d;
  logic [3:0]               wait_q, wait_d;
  logic                     is_write_q, is_write_d;
  logic [31:0]              addr_q, addr_d;
  logic [31:0]              wdata_q, wdata_d;
  logic [23:0]              rword_q, rword_d;
  logic [31:0]              read_data_q, read_data_d;
  logic                     ready_q, ready_d;
  logic [31:0]              addr_req_q, addr_req_d;
  logic [ADDRESS_WIDTH-1:0] sram_address_q, sram_address_d;
  logic [7:0]               sram_dout_q, sram_dout_d;
  logic                     sram_data_oe_q, sram_data_oe_d;
  logic                     sram_we_n_q, sram_we_n_d;
  logic                     sram_oe_n_q, sram_oe_n_d;
  logic [1:0]               beat_nx;
  logic                     unused_addr_bits;
`ifdef SRAM_READ_BUFFER_EN
  logic [ADDRESS_WIDTH-3:0] buf_tag_q, buf_tag_d;
  logic [31:0]              buf_data_q, buf_data_d;
  logic                     buf_valid_q, buf_valid_d;
  logic                     buf_hit;

  assign buf_hit = buf_valid_q && (buf_tag_q == address[ADDRESS_WIDTH-1:2]);
`endif

  assign unused_addr_bits = ^address[1:0];
  assign beat_nx          = beat_q + 2'd1;

  always_comb begin
    state_d        = state_q;
    beat_d         = beat_q;
    wait_d         = wait_q;
    is_write_d     = is_write_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    rword_d        = rword_q;
    read_data_d    = read_data_q;
    ready_d        = 1'b0;
    addr_req_d     = addr_req_q;
    sram_address_d = sram_address_q;
    sram_dout_d    = sram_dout_q;
    sram_data_oe_d = sram_data_oe_q;
    sram_we_n_d    = sram_we_n_q;
    sram_oe_n_d    = sram_oe_n_q;
`ifdef SRAM_READ_BUFFER_EN
    buf_tag_d      = buf_tag_q;
    buf_data_d     = buf_data_q;
    buf_valid_d    = buf_valid_q;
`endif
    case (state_q)
      IDLE: begin
        if (write || read) begin
          addr_d         = {address[31:2], 2'b00};
          wdata_d        = write_data;
          is_write_d     = write;
          beat_d         = 2'd0;
          wait_d         = 4'd0;
          state_d        = SETUP;
          sram_address_d = {address[ADDRESS_WIDTH-1:2], 2'b00};
          sram_dout_d    = write_data[7:0];
          sram_data_oe_d = write;
`ifdef SRAM_READ_BUFFER_EN
          if (write) begin
            buf_valid_d = 1'b0;
          end else if (buf_hit) begin
            // Buffered word: complete straight away and leave the SRAM pins alone.
            state_d        = DONE;
            ready_d        = 1'b1;
            read_data_d    = buf_data_q;
            addr_req_d     = {address[31:2], 2'b00};
            sram_address_d = sram_address_q;
            sram_dout_d    = sram_dout_q;
            sram_data_oe_d = 1'b0;
          end
`endif
        end
      end
      SETUP: begin
        state_d     = STROBE;
        wait_d      = 4'd0;
        sram_we_n_d = !is_write_q;
        sram_oe_n_d = is_write_q;
      end
      STROBE: begin
        if (wait_q == LAST_WAIT) begin
          sram_we_n_d = 1'b1;
          sram_oe_n_d = 1'b1;
          case (beat_q)
            2'd0:    rword_d[7:0]   = sram_data_in;
            2'd1:    rword_d[15:8]  = sram_data_in;
            2'd2:    rword_d[23:16] = sram_data_in;
            default: rword_d        = rword_q;
          endcase
          if (beat_q == 2'd3) begin
            state_d        = DONE;
            ready_d        = 1'b1;
            addr_req_d     = addr_q;
            sram_data_oe_d = 1'b0;
            if (!is_write_q) begin
              read_data_d = {sram_data_in, rword_q};
`ifdef SRAM_READ_BUFFER_EN
              buf_tag_d   = addr_q[ADDRESS_WIDTH-1:2];
              buf_data_d  = {sram_data_in, rword_q};
              buf_valid_d = 1'b1;
`endif
            end
          end else begin
            state_d        = SETUP;
            beat_d         = beat_nx;
            sram_address_d = {addr_q[ADDRESS_WIDTH-1:2], beat_nx};
            sram_dout_d    = wdata_q[{beat_nx, 3'b000} +: 8];
          end
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      beat_q         <= 2'd0;
      wait_q         <= 4'd0;
      is_write_q     <= 1'b0;
      addr_q         <= 32'd0;
      wdata_q        <= 32'd0;
      rword_q        <= 24'd0;
      read_data_q    <= 32'd0;
      ready_q        <= 1'b0;
      addr_req_q     <= 32'd0;
      sram_address_q <= '0;
      sram_dout_q    <= 8'd0;
      sram_data_oe_q <= 1'b0;
      sram_we_n_q    <= 1'b1;
      sram_oe_n_q    <= 1'b1;
    end else begin
      state_q        <= state_d;
      beat_q         <= beat_d;
      wait_q         <= wait_d;
      is_write_q     <= is_write_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      rword_q        <= rword_d;
      read_data_q    <= read_data_d;
      ready_q        <= ready_d;
      addr_req_q     <= addr_req_d;
      sram_address_q <= sram_address_d;
      sram_dout_q    <= sram_dout_d;
      sram_data_oe_q <= sram_data_oe_d;
      sram_we_n_q    <= sram_we_n_d;
      sram_oe_n_q    <= sram_oe_n_d;
    end
  end

`ifdef SRAM_READ_BUFFER_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      buf_tag_q   <= '0;
      buf_data_q  <= 32'd0;
      buf_valid_q <= 1'b0;
    end else begin
      buf_tag_q   <= buf_tag_d;
      buf_data_q  <= buf_data_d;
      buf_valid_q <= buf_valid_d;
    end
  end
`endif

  assign read_data         = read_data_q;
  assign ready             = ready_q;
  assign address_requested = addr_req_q;
  assign sram_address      = sram_address_q;
  assign sram_data_out     = sram_dout_q;
  assign sram_data_oe      = sram_data_oe_q;
  assign sram_we_n         = sram_we_n_q;
  assign sram_oe_n         = sram_oe_n_q;
endmodule

// File: doc/riscv_sram_controller.md
RISCV_SRAM_CONTROLLER -- requirements
Module: riscv_sram_controller

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 18, byte-address width of the external SRAM.
REQ-002 Parameter WAIT_CYCLES, default 1, extra strobe cycles per byte beat; legal range 0..15.
REQ-003 Clock and reset: one clock; reset is synchronous and active-high.
REQ-004 clock  input  1  sole clock, rising edge.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 address  input  32  word request address from the bus; bits [1:0] ignored.
REQ-007 read  input  1  read request.
REQ-008 write  input  1  write request.
REQ-009 write_data  input  32  word to write.
REQ-010 read_data  output  32  word read.
REQ-011 ready  output  1  one-cycle completion pulse.
REQ-012 address_requested  output  32  address of the completing request, bits [1:0] = 0.
REQ-013 sram_address  output  ADDRESS_WIDTH  SRAM byte address.
REQ-014 sram_data_out  output  8  byte driven to SRAM.
REQ-015 sram_data_in  input  8  byte returned by SRAM.
REQ-016 sram_data_oe  output  1  tristate enable for sram_data_out.
REQ-017 sram_we_n, sram_oe_n  output  1 each  active-low strobes.

Function
REQ-018 FSM states IDLE, SETUP, STROBE, DONE; all outputs registered.
REQ-019 IDLE accepts a request at a rising edge where read or write is high; address, write_data and operation are latched; write wins if both are high.
REQ-020 Each transfer is 4 byte beats, beat b = 0..3 little-endian (beat 0 = bits 7:0); sram_address = {address[ADDRESS_WIDTH-1:2], b}.
REQ-021 Beat = 1 SETUP cycle (strobes high, address and data stable) + WAIT_CYCLES+1 STROBE cycles (sram_oe_n low on reads, sram_we_n low on writes).
REQ-022 Read byte sampled from sram_data_in at the edge ending the last STROBE cycle of its beat.
REQ-023 sram_data_oe high throughout every write beat, low otherwise; sram_data_out = addressed byte of latched write_data.
REQ-024 After beat 3, DONE lasts exactly one cycle: ready=1, address_requested = latched address, read_data = assembled word on reads (unchanged on writes).
REQ-025 Latency: request accepted at edge T0 -> ready high in cycle T0 + 4*(WAIT_CYCLES+2) + 1; WAIT_CYCLES=1 gives ready 13 cycles after acceptance.
REQ-026 No request is accepted outside IDLE or in DONE; requesters hold read/write until ready and drop it the cycle ready is seen; a request still high in the cycle after DONE is a new request.
REQ-027 read_data holds its value until the next read completion.
REQ-028 Address bits above ADDRESS_WIDTH-1 are ignored (aliasing), no error.

Reset
REQ-029 Reset: state IDLE, ready=0, read_data=0, address_requested=0, sram_address=0, sram_data_out=0, sram_data_oe=0, sram_we_n=1, sram_oe_n=1.
REQ-030 Reset mid-transfer aborts at the next edge: strobes high, no ready pulse, partial read data discarded, partially written SRAM bytes left as written.

Configuration
REQ-031 Macro SRAM_READ_BUFFER_EN compiled in: a one-word buffer (tag, data, valid) holds the last completed read.
REQ-032 With SRAM_READ_BUFFER_EN, a read whose word address matches a valid tag skips SRAM: DONE follows acceptance, ready high in cycle T0+1, SRAM strobes stay high.
REQ-033 With SRAM_READ_BUFFER_EN, any accepted write invalidates the buffer regardless of address; reset invalidates it.
REQ-034 Without SRAM_READ_BUFFER_EN, every read runs the full SRAM sequence and no buffer logic exists.

Verification
REQ-035 WAIT_CYCLES=1, write 0xDEADBEEF to 0x100 -> bytes EF,BE,AD,DE on sram_address 0x100..0x103, we_n low 2 cycles per beat, ready in cycle T0+13, address_requested=0x100.
REQ-036 Read 0x100 after REQ-035 -> oe_n pulses 4 times, read_data=0xDEADBEEF with ready in cycle T0+13; with buffer, a repeated read -> ready in T0+1, no strobes.
REQ-037 read and write both high, address 0x204, write_data 0x12345678 -> write performed, subsequent read returns 0x12345678.
REQ-038 Reset asserted during beat 2 of a read -> next cycle strobes high, no ready, next request accepted normally with full latency.
REQ-039 WAIT_CYCLES=0 and address 0xFFFFFFFC, ADDRESS_WIDTH=18 -> sram_address 0x3FFFC..0x3FFFF, ready in cycle T0+9, address_requested=0xFFFFFFFC.
REQ-040 Buffer enabled: read 0x40, write 0x80, read 0x40 -> second read runs full SRAM sequence.
